// File: rtl/ball_motion_if.sv
// ball_motion_if -- signal bundle between the video pipeline and ball_motion.
//
// Signals:
//   vsync      : active-low vertical sync from the XVGA timing generator
//   pspeed     : ball speed in pixels per frame (both axes)
//   paddle_y   : top row of the paddle
//   ball_x     : left column of the ball
//   ball_y     : top row of the ball
//   game_over  : high once the ball has been missed
//   frame_tick : one-cycle pulse following every frame update
//
// Modports:
//   master : the side that drives sync/speed/paddle and consumes the ball state
//   slave  : the ball_motion block itself
interface ball_motion_if;
  logic        vsync;
  logic [3:0]  pspeed;
  logic [9:0]  paddle_y;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic        game_over;
  logic        frame_tick;

  modport master (
    output vsync, pspeed, paddle_y,
    input  ball_x, ball_y, game_over, frame_tick
  );

  modport slave (
    input  vsync, pspeed, paddle_y,
    output ball_x, ball_y, game_over, frame_tick
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion -- Pong ball kinematics on a fixed 1024x768 playfield.
//
// Once per frame (on the falling edge of vsync) the ball is served, moved,
// bounced off the right/top/bottom walls or the paddle on the left, or
// declared missed. A miss freezes the game until reset.
//
// Ports:
//   vclock : 65 MHz pixel clock, the only clock
//   reset  : synchronous, active-high
//   bus    : ball_motion_if.slave (vsync, pspeed, paddle_y in;
//            ball_x, ball_y, game_over, frame_tick out, all registered)
module ball_motion #(
  parameter int BALL_SIZE    = 32,
  parameter int PADDLE_W     = 16,
  parameter int PADDLE_H     = 128,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         vclock,
  input  logic         reset,
  ball_motion_if.slave bus
);

  typedef enum logic [1:0] {SERVE, RUN, OVER} state_t;

  // All motion arithmetic is done 12 bits wide so sums never wrap.
  localparam logic [11:0] BS12     = 12'(BALL_SIZE);
  localparam logic [11:0] PW12     = 12'(PADDLE_W);
  localparam logic [11:0] PH12     = 12'(PADDLE_H);
  localparam logic [11:0] X_MAX    = 12'(1024 - BALL_SIZE);
  localparam logic [11:0] Y_MAX    = 12'(768 - BALL_SIZE);
  localparam logic [10:0] SERVE_X  = 11'd496;
  localparam logic [9:0]  SERVE_Y  = 10'd368;
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);

  state_t      state_q, state_d;
  logic [7:0]  serve_cnt_q, serve_cnt_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dx_q, dx_d;
  logic        dy_q, dy_d;
  logic        game_over_q, game_over_d;
  logic        frame_tick_q;
  logic        vsync_d_q;

  logic        tick;
  logic        miss;
  logic        hit;
  logic [11:0] s12, x12, y12, py12;

  // Frame boundary: vsync was high last cycle and is low now.
  assign tick = vsync_d_q & ~bus.vsync;

  assign s12  = {8'd0, bus.pspeed};
  assign x12  = {1'b0, x_q};
  assign y12  = {2'b0, y_q};
  assign py12 = {2'b0, bus.paddle_y};

  // Vertical overlap of ball and paddle, using the pre-update ball row.
  assign hit = (y12 + BS12 > py12) && (y12 < py12 + PH12);

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    miss        = 1'b0;

    if (tick) begin
      case (state_q)
        SERVE: begin
          // The launch tick itself does not move the ball.
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = RUN;
            serve_cnt_d = 8'd0;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end

        RUN: begin
          // Horizontal axis.
          if (dx_q) begin
            if (x12 + s12 + BS12 >= 12'd1024) begin
              x_d  = 11'(X_MAX);
              dx_d = 1'b0;
            end else begin
              x_d = 11'(x12 + s12);
            end
          end else if (x12 < PW12 + s12) begin
            if (hit) begin
              x_d  = 11'(PW12);
              dx_d = 1'b1;
            end else begin
              x_d     = 11'd0;
              state_d = OVER;
              miss    = 1'b1;
            end
          end else begin
            x_d = 11'(x12 - s12);
          end

          // Vertical axis, independent of the horizontal one except that a
          // miss leaves the row untouched.
          if (!miss) begin
            if (dy_q) begin
              if (y12 + s12 + BS12 >= 12'd768) begin
                y_d  = 10'(Y_MAX);
                dy_d = 1'b0;
              end else begin
                y_d = 10'(y12 + s12);
              end
            end else if (y12 < s12) begin
              y_d  = 10'd0;
              dy_d = 1'b1;
            end else begin
              y_d = 10'(y12 - s12);
            end
          end
        end

        default: begin
          // OVER: everything frozen until reset.
        end
      endcase
    end

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state_q      <= SERVE;
      serve_cnt_q  <= 8'd0;
      x_q          <= SERVE_X;
      y_q          <= SERVE_Y;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
      game_over_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      vsync_d_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      game_over_q  <= game_over_d;
      frame_tick_q <= tick;
      vsync_d_q    <= bus.vsync;
    end
  end

  assign bus.ball_x     = x_q;
  assign bus.ball_y     = y_q;
  assign bus.game_over  = game_over_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion -- self-checking bench for ball_motion.
// A behavioural model (plain integers) tracks the ball frame by frame and
// every frame's outputs are compared against it, alongside hand-derived
// values for the directed scenarios.
module tb_ball_motion;

  logic clk = 1'b0;
  logic rst;

  ball_motion_if bus ();

  ball_motion #(
    .BALL_SIZE(32), .PADDLE_W(16), .PADDLE_H(128), .SERVE_FRAMES(60)
  ) dut (
    .vclock(clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  int m_x, m_y, m_dx, m_dy, m_cnt;
  int m_st;          // 0 serve, 1 run, 2 over
  int corners = 0;
  int misses  = 0;

  task automatic model_reset();
    m_x = 496; m_y = 368; m_dx = 1; m_dy = 1; m_cnt = 0; m_st = 0;
  endtask

  task automatic model_tick(input int s, input int py);
    int  flips;
    bit  missed;
    flips  = 0;
    missed = 0;
    if (m_st == 0) begin
      if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (m_st == 1) begin
      if (m_dx == 1) begin
        if (m_x + s + 32 >= 1024) begin m_x = 992; m_dx = 0; flips++; end
        else m_x = m_x + s;
      end else if (m_x < 16 + s) begin
        if ((m_y + 32 > py) && (m_y < py + 128)) begin m_x = 16; m_dx = 1; flips++; end
        else begin m_x = 0; m_st = 2; missed = 1; misses++; end
      end else begin
        m_x = m_x - s;
      end
      if (!missed) begin
        if (m_dy == 1) begin
          if (m_y + s + 32 >= 768) begin m_y = 736; m_dy = 0; flips++; end
          else m_y = m_y + s;
        end else if (m_y < s) begin
          m_y = 0; m_dy = 1; flips++;
        end else begin
          m_y = m_y - s;
        end
      end
      if (flips == 2) corners++;
    end
  endtask

  // Pure stimulus: one frame. Junk is put on pspeed/paddle_y while vsync is
  // high, the intended values are applied together with the falling edge.
  // Returns #1 after the tick edge with the model already updated.
  task automatic tick_frame(input logic [3:0] ps, input logic [9:0] py);
    @(negedge clk);
    bus.vsync    = 1'b1;
    bus.pspeed   = 4'($urandom);
    bus.paddle_y = 10'($urandom);
    @(negedge clk);
    bus.vsync    = 1'b0;
    bus.pspeed   = ps;
    bus.paddle_y = py;
    @(posedge clk);
    model_tick(int'(ps), int'(py));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vsync = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.ball_x !== 11'd496) begin miscompares++; $display("FAIL reset_x: got %0d expected 496", bus.ball_x); end
    vectors++; if (bus.ball_y !== 10'd368) begin miscompares++; $display("FAIL reset_y: got %0d expected 368", bus.ball_y); end
    vectors++; if (bus.game_over !== 1'b0) begin miscompares++; $display("FAIL reset_go: got %0b expected 0", bus.game_over); end
    vectors++; if (bus.frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_ft: got %0b expected 0", bus.frame_tick); end
    $display("test_reset done: ball=(%0d,%0d)", bus.ball_x, bus.ball_y);
  endtask

  task automatic test_serve();
    apply_reset();
    for (int f = 1; f <= 60; f++) begin
      tick_frame(4'd4, 10'd0);
      vectors++; if (bus.ball_x !== 11'd496 || bus.ball_y !== 10'd368) begin
        miscompares++; $display("FAIL serve_hold f%0d: got (%0d,%0d) expected (496,368)", f, bus.ball_x, bus.ball_y);
      end
      vectors++; if (bus.frame_tick !== 1'b1) begin
        miscompares++; $display("FAIL serve_ft f%0d: got %0b expected 1", f, bus.frame_tick);
      end
    end
    tick_frame(4'd4, 10'd0);
    vectors++; if (bus.ball_x !== 11'd500 || bus.ball_y !== 10'd372) begin
      miscompares++; $display("FAIL serve_launch: got (%0d,%0d) expected (500,372)", bus.ball_x, bus.ball_y);
    end
    $display("test_serve done: ball=(%0d,%0d)", bus.ball_x, bus.ball_y);
  endtask

  // Continues from the launched ball (500, moving right at 4 px/frame).
  task automatic test_right_wall();
    for (int f = 0; f < 122; f++) begin
      tick_frame(4'd4, 10'd0);
      vectors++; if (int'(bus.ball_x) != m_x || int'(bus.ball_y) != m_y) begin
        miscompares++; $display("FAIL rw_track f%0d: got (%0d,%0d) expected (%0d,%0d)", f, bus.ball_x, bus.ball_y, m_x, m_y);
      end
    end
    vectors++; if (bus.ball_x !== 11'd988) begin
      miscompares++; $display("FAIL rw_approach: got %0d expected 988", bus.ball_x);
    end
    tick_frame(4'd8, 10'd0);
    vectors++; if (bus.ball_x !== 11'd992) begin
      miscompares++; $display("FAIL rw_clamp: got %0d expected 992", bus.ball_x);
    end
    tick_frame(4'd8, 10'd0);
    vectors++; if (bus.ball_x !== 11'd984) begin
      miscompares++; $display("FAIL rw_reverse: got %0d expected 984", bus.ball_x);
    end
    vectors++; if (int'(bus.ball_y) != m_y) begin
      miscompares++; $display("FAIL rw_y: got %0d expected %0d", bus.ball_y, m_y);
    end
    $display("test_right_wall done: ball=(%0d,%0d)", bus.ball_x, bus.ball_y);
  endtask

  // Continues with the ball heading left; the paddle is parked below the
  // playfield so the ball must be missed.
  task automatic test_miss();
    int          f;
    logic [10:0] fx;
    logic [9:0]  fy;
    f = 0;
    while (m_st != 2 && f < 400) begin
      tick_frame(4'($urandom_range(1, 15)), 10'd900);
      vectors++; if (int'(bus.ball_x) != m_x || int'(bus.ball_y) != m_y || bus.game_over !== (m_st == 2)) begin
        miscompares++; $display("FAIL miss_track f%0d: got (%0d,%0d,go=%0b) expected (%0d,%0d,go=%0b)",
                                f, bus.ball_x, bus.ball_y, bus.game_over, m_x, m_y, m_st == 2);
      end
      f++;
    end
    vectors++; if (bus.ball_x !== 11'd0 || bus.game_over !== 1'b1) begin
      miscompares++; $display("FAIL miss_over: got x=%0d go=%0b expected x=0 go=1", bus.ball_x, bus.game_over);
    end
    fx = bus.ball_x;
    fy = bus.ball_y;
    for (int k = 0; k < 10; k++) begin
      tick_frame(4'($urandom_range(1, 15)), 10'($urandom));
      vectors++; if (bus.ball_x !== fx || bus.ball_y !== fy || bus.game_over !== 1'b1) begin
        miscompares++; $display("FAIL over_frozen k%0d: got (%0d,%0d,go=%0b) expected (%0d,%0d,go=1)",
                                k, bus.ball_x, bus.ball_y, bus.game_over, fx, fy);
      end
    end
    apply_reset();
    vectors++; if (bus.ball_x !== 11'd496 || bus.ball_y !== 10'd368 || bus.game_over !== 1'b0) begin
      miscompares++; $display("FAIL over_reset: got (%0d,%0d,go=%0b) expected (496,368,go=0)", bus.ball_x, bus.ball_y, bus.game_over);
    end
    $display("test_miss done: missed after %0d frames", f);
  endtask

  task automatic test_tick_pulse();
    int pulses;
    apply_reset();
    // Launch and run a few frames so a swallowed tick would be visible.
    for (int f = 0; f < 63; f++) tick_frame(4'd3, 10'd0);
    @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync  = 1'b0;
    bus.pspeed = 4'd3;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (c == 0) model_tick(3, 0);
      #1;
      if (bus.frame_tick === 1'b1) pulses++;
    end
    vectors++; if (pulses != 1) begin
      miscompares++; $display("FAIL tick_once: got %0d pulses expected 1", pulses);
    end
    vectors++; if (int'(bus.ball_x) != m_x || int'(bus.ball_y) != m_y) begin
      miscompares++; $display("FAIL tick_pos: got (%0d,%0d) expected (%0d,%0d)", bus.ball_x, bus.ball_y, m_x, m_y);
    end
    // Reset coincides with a tick edge: reset values, no pulse.
    @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (bus.ball_x !== 11'd496 || bus.ball_y !== 10'd368 || bus.game_over !== 1'b0) begin
      miscompares++; $display("FAIL rst_on_tick_pos: got (%0d,%0d,go=%0b) expected (496,368,go=0)", bus.ball_x, bus.ball_y, bus.game_over);
    end
    vectors++; if (bus.frame_tick !== 1'b0) begin
      miscompares++; $display("FAIL rst_on_tick_ft: got %0b expected 0", bus.frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.vsync = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    vectors++; if (bus.frame_tick !== 1'b0) begin
      miscompares++; $display("FAIL rst_on_tick_after: got %0b expected 0", bus.frame_tick);
    end
    $display("test_tick_pulse done: pulses=%0d", pulses);
  endtask

  // Several games with random speed (including zero) and a paddle that
  // usually tracks the ball; each game ends with a reset, often mid-RUN.
  task automatic test_random_games();
    logic [3:0] ps;
    int         py;
    int         tail;
    for (int g = 0; g < 6; g++) begin
      apply_reset();
      tail = 0;
      for (int f = 0; f < 500 && tail < 4; f++) begin
        ps = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        if ($urandom_range(0, 19) != 0) begin
          py = m_y - int'($urandom_range(0, 120));
          if (py < 0) py = 0;
        end else begin
          py = int'($urandom_range(0, 1023));
        end
        tick_frame(ps, 10'(py));
        vectors++; if (int'(bus.ball_x) != m_x || int'(bus.ball_y) != m_y ||
                       bus.game_over !== (m_st == 2) || bus.frame_tick !== 1'b1) begin
          miscompares++; $display("FAIL rand g%0d f%0d: got (%0d,%0d,go=%0b,ft=%0b) expected (%0d,%0d,go=%0b,ft=1)",
                                  g, f, bus.ball_x, bus.ball_y, bus.game_over, bus.frame_tick, m_x, m_y, m_st == 2);
        end
        if (m_st == 2) tail++;
      end
      apply_reset();
      vectors++; if (bus.ball_x !== 11'd496 || bus.ball_y !== 10'd368 || bus.game_over !== 1'b0) begin
        miscompares++; $display("FAIL rand_reset g%0d: got (%0d,%0d,go=%0b) expected (496,368,go=0)",
                                g, bus.ball_x, bus.ball_y, bus.game_over);
      end
      $display("game %0d done: corners=%0d misses=%0d", g, corners, misses);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.vsync    = 1'b1;
    bus.pspeed   = 4'd0;
    bus.paddle_y = 10'd0;
    repeat (3) @(posedge clk);
    test_reset();
    test_serve();
    test_right_wall();
    test_miss();
    test_tick_pulse();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
